// File: rtl/adapter_bram_2_axis_prefetch.sv
// rtl/adapter_bram_2_axis_prefetch.sv - BRAM ping-pong half to AXI-Stream packet adapter with credit-based prefetch
//
// Reads i_bram_size words from a BRAM half and emits them as one AXI-Stream packet.
// Reads are issued ahead of the sink through a READ_LATENCY-deep in-flight pipe into a
// FIFO_DEPTH-entry decoupling FIFO. A ready sink therefore sees back-to-back beats.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_bram_en         level: half owned by this block; dropping it mid-packet aborts
//   i_bram_size       packet length in words, sampled when leaving IDLE
//   o_bram_addr       BRAM read address
//   o_bram_rd         BRAM read strobe, one word per asserted cycle
//   i_bram_data       BRAM read data, READ_LATENCY cycles after the strobe
//   o_done            packet fully accepted; held until i_bram_en falls
//   i_axis_user       passed through combinationally to o_axis_user
//   i_axis_ready      TREADY
//   o_axis_data       TDATA (FIFO head)
//   o_axis_last       TLAST
//   o_axis_valid      TVALID (FIFO non-empty)
//
// Optional feature macro ADAPTER_BRAM_AXIS_KEEP_EN adds:
//   i_last_keep       byte enables for the final beat, sampled with i_bram_size (0 = all bytes)
//   o_axis_keep       TKEEP: all-ones except on the TLAST beat
module adapter_bram_2_axis_prefetch #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int BRAM_DEPTH      = 8,
  parameter int READ_LATENCY    = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int USER_DEPTH      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_bram_en,
  input  logic [BRAM_DEPTH:0]          i_bram_size,
  output logic [BRAM_DEPTH-1:0]        o_bram_addr,
  output logic                         o_bram_rd,
  input  logic [AXIS_DATA_WIDTH-1:0]   i_bram_data,
  output logic                         o_done,
  input  logic [USER_DEPTH-1:0]        i_axis_user,
  output logic [USER_DEPTH-1:0]        o_axis_user,
  input  logic                         i_axis_ready,
  output logic [AXIS_DATA_WIDTH-1:0]   o_axis_data,
  output logic                         o_axis_last,
  output logic                         o_axis_valid
`ifdef ADAPTER_BRAM_AXIS_KEEP_EN
  ,
  input  logic [AXIS_DATA_WIDTH/8-1:0] i_last_keep,
  output logic [AXIS_DATA_WIDTH/8-1:0] o_axis_keep
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Occupancy spans FIFO entries, the in-flight pipe and the strobe on the bus this cycle.
  localparam int OW = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
  localparam logic [BRAM_DEPTH:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                       state;
  logic [BRAM_DEPTH:0]          size;
  logic [BRAM_DEPTH:0]          rd_cnt;
  logic [BRAM_DEPTH:0]          tx_cnt;
  logic [READ_LATENCY-1:0]      pipe;
  logic [AXIS_DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [CW-1:0]                count;
  logic [OW-1:0]                pipe_cnt;
  logic [OW-1:0]                occ;
  logic                         active;
  logic                         push;
  logic                         fire;
  logic                         credit;
  logic                         issue;

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      pipe_cnt = pipe_cnt + OW'(pipe[i]);
    end
  end

  assign active       = (state == READ || state == DRAIN) && i_bram_en;
  assign push         = pipe[READ_LATENCY-1] && active;
  assign o_axis_valid = (count != '0);
  assign fire         = o_axis_valid && i_axis_ready;
  assign occ          = OW'(count) + pipe_cnt + OW'(o_bram_rd);
  // A pop this cycle frees a slot before the new word can land, so it counts as credit.
  assign credit       = (occ - OW'(fire)) < OW'(FIFO_DEPTH);
  assign issue        = (state == READ) && (rd_cnt < size) && credit;

  assign o_axis_data  = mem[rd_ptr];
  assign o_axis_last  = o_axis_valid && ((tx_cnt + CNT_ONE) == size);
  assign o_axis_user  = i_axis_user;

`ifdef ADAPTER_BRAM_AXIS_KEEP_EN
  logic [AXIS_DATA_WIDTH/8-1:0] last_keep_q;
  assign o_axis_keep = o_axis_last ? last_keep_q : '1;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_bram_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      size        <= '0;
      rd_cnt      <= '0;
      tx_cnt      <= '0;
      pipe        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_bram_rd   <= 1'b0;
      o_bram_addr <= '0;
      o_done      <= 1'b0;
`ifdef ADAPTER_BRAM_AXIS_KEEP_EN
      last_keep_q <= '1;
`endif
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[0] <= o_bram_rd;

      case (state)
        IDLE: begin
          o_bram_rd <= 1'b0;
          o_done    <= 1'b0;
          if (i_bram_en) begin
            size        <= i_bram_size;
            tx_cnt      <= '0;
            o_bram_addr <= '0;
`ifdef ADAPTER_BRAM_AXIS_KEEP_EN
            last_keep_q <= (i_last_keep == '0) ? '1 : i_last_keep;
`endif
            if (i_bram_size == '0) begin
              rd_cnt <= '0;
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              // The FIFO is empty here, so the first word can be requested immediately.
              o_bram_rd <= 1'b1;
              rd_cnt    <= CNT_ONE;
              state     <= (i_bram_size == CNT_ONE) ? DRAIN : READ;
            end
          end
        end

        READ, DRAIN: begin
          if (!i_bram_en) begin
            // Owner took the half back mid-packet: drop everything, no done indication.
            state     <= IDLE;
            o_bram_rd <= 1'b0;
            pipe      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
          end else begin
            if (push) begin
              wr_ptr <= wr_ptr + PW'(1);
            end
            if (fire) begin
              rd_ptr <= rd_ptr + PW'(1);
              tx_cnt <= tx_cnt + CNT_ONE;
            end
            count <= count + CW'(push) - CW'(fire);

            if (state == READ) begin
              o_bram_rd <= issue;
              if (issue) begin
                o_bram_addr <= rd_cnt[BRAM_DEPTH-1:0];
                rd_cnt      <= rd_cnt + CNT_ONE;
                if ((rd_cnt + CNT_ONE) == size) begin
                  state <= DRAIN;
                end
              end
            end else begin
              o_bram_rd <= 1'b0;
              if (fire && o_axis_last) begin
                state  <= DONE;
                o_done <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          o_bram_rd <= 1'b0;
          if (!i_bram_en) begin
            state  <= IDLE;
            o_done <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
